// File: rtl/aes_pkg.sv
// AES-128 shared constants and datapath helpers.
// State and key bytes are packed big-endian: byte 0 sits in bits [127:120].
package aes_pkg;

  localparam int NR = 10;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [79:0] RCON_TBL = 80'h01020408102040801b36;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[2047-8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] rcon_at(input int i);
    return RCON_TBL[79-8*i -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int n = 0; n < 16; n++)
      r[127-8*n -: 8] = sbox(s[127-8*n -: 8]);
    return r;
  endfunction

  // Byte n lives at row n%4, column n/4; row r rotates left by r.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int row = 0; row < 4; row++)
      for (int c = 0; c < 4; c++)
        r[127-8*(row+4*c) -: 8] =
          s[127-8*(row+4*((c+row)%4)) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 32] = {
        xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
        a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
        a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
        xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
      };
    end
    return r;
  endfunction

  function automatic logic [127:0] key_expand(
    input logic [127:0] k,
    input logic [7:0]   rcon
  );
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96] ^ 32'h0;
    w3 = k[31:0];
    t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h0};
    w0 = w0 ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_round_stage.sv
// One pipelined AES round with its own key-expansion step.
// The final round skips MixColumns.
module aes_round_stage
  import aes_pkg::*;
#(
  parameter bit FINAL = 1'b0
) (
  input  logic         clk1,
  input  logic         rst_n,
  input  logic [127:0] i_state,
  input  logic [127:0] i_key,
  input  logic [7:0]   i_rcon,
  output logic [127:0] o_state,
  output logic [127:0] o_key
);

  logic [127:0] w_rk;
  logic [127:0] w_sr;
  logic [127:0] w_mc;
  logic [127:0] r_state;
  logic [127:0] r_key;

  assign w_rk = key_expand(i_key, i_rcon);
  assign w_sr = shift_rows(sub_bytes(i_state));
  assign w_mc = FINAL ? w_sr : mix_columns(w_sr);

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_key   <= '0;
    end else begin
      r_state <= w_mc ^ w_rk;
      r_key   <= w_rk;
    end
  end

  assign o_state = r_state;
  assign o_key   = r_key;

endmodule

// File: rtl/aes128_encryptor_top.sv
// Fully unrolled AES-128 ECB encryptor, one block per clock.
// Round keys travel alongside their block, so the key may change every cycle.
module aes128_encryptor_top
  import aes_pkg::*;
(
  input  logic         clk1,
  input  logic         rst_n,
  input  logic [127:0] key1,
  input  logic [127:0] in_text,
  output logic [127:0] out_128
);

  logic [127:0] w_state [0:NR];
  logic [127:0] w_key   [0:NR];

  assign w_state[0] = in_text ^ key1;
  assign w_key[0]   = key1;

  for (genvar i = 0; i < NR; i++) begin : g_rnd
    aes_round_stage #(
      .FINAL (i == NR-1)
    ) u_stage (
      .clk1    (clk1),
      .rst_n   (rst_n),
      .i_state (w_state[i]),
      .i_key   (w_key[i]),
      .i_rcon  (rcon_at(i)),
      .o_state (w_state[i+1]),
      .o_key   (w_key[i+1])
    );
  end

  assign out_128 = w_state[NR];

endmodule

// File: tb/tb_aes128_encryptor_top.sv
// Directed FIPS-197 vector bench for aes128_encryptor_top.
// Expected ciphertexts are published AES-128 test vectors.
module tb_aes128_encryptor_top;

  localparam logic [127:0] KA  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PA1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] PA2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CA1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] CA2 = 128'hf5d3d58503b9699de785895a96fdbaaf;
  localparam logic [127:0] KB  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PB  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CB  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CZ  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk1;
  logic         rst_n;
  logic [127:0] key1;
  logic [127:0] in_text;
  logic [127:0] out_128;

  int checks;
  int failures;

  aes128_encryptor_top dut (
    .clk1    (clk1),
    .rst_n   (rst_n),
    .key1    (key1),
    .in_text (in_text),
    .out_128 (out_128)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk1);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [127:0] exp);
    checks++;
    assert (out_128 === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, out_128, exp);
    end
  endtask

  task automatic check_ne(input string tag, input logic [127:0] bad);
    checks++;
    assert (out_128 !== bad) else begin
      failures++;
      $error("FAIL %s observed=%h expected_not=%h", tag, out_128, bad);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    key1     = '0;
    in_text  = '0;

    #3;
    check("reset_t0", 128'h0);
    step(1);
    check("reset_after_edge", 128'h0);

    rst_n = 1'b1;
    step(10);
    check("zero_key_zero_pt", CZ);

    key1 = KA; in_text = PA1;
    step(9);
    check_ne("latency_not_early", CA1);
    step(1);
    check("fips_keyA_pt1", CA1);
    step(1);
    check("fips_keyA_hold", CA1);

    key1 = KB; in_text = PB;
    step(10);
    check("fips_keyB", CB);

    key1 = KA; in_text = PA1;
    step(1);
    in_text = PA2;
    step(9);
    check("b2b_first", CA1);
    step(1);
    check("b2b_second", CA2);

    for (int i = 0; i < 14; i++) begin
      key1    = (i % 2 == 0) ? KA : KB;
      in_text = (i % 2 == 0) ? PA1 : PB;
      step(1);
      if (i >= 9)
        check($sformatf("alt_key_%0d", i),
              ((i - 9) % 2 == 0) ? CA1 : CB);
    end

    key1 = KA; in_text = PA1;
    step(12);
    check("pre_reset_full", CA1);
    #2;
    rst_n   = 1'b0;
    key1    = '0;
    in_text = '0;
    #1;
    check("async_reset_clear", 128'h0);
    #2;
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (k < 10)
        check_ne($sformatf("no_stale_%0d", k), CA1);
      else
        check($sformatf("post_reset_zero_%0d", k), CZ);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
